// File: rtl/bitpack8_pkg.sv
// Shared constants and descriptor/codeword types for the bitpack8 JPEG-LS bit packer.
// Optional frame bit counter is enabled by defining BITPACK_BITCNT_EN.
package bitpack_pkg;

    localparam int NLANE        = 8;
    localparam int LANE_MAXBITS = 92;
    localparam int GRP_MAXBITS  = 736;
    localparam int WW           = 64;
    localparam int NWORD        = 13;

    typedef struct packed {
        logic        vl;
        logic [4:0]  oc;
        logic [14:0] pv;
        logic [3:0]  pc;
        logic [4:0]  zc;
        logic [8:0]  bv;
        logic [3:0]  bc;
    } lane_desc_t;

    typedef struct packed {
        logic [LANE_MAXBITS-1:0] code;
        logic [6:0]              len;
    } lane_code_t;

endpackage

// File: rtl/bitpack8_lane.sv
// One lane's codeword: ones, run remainder, unary zeros, suffix bits, left-aligned in 92 bits.
module bitpack_lane
    import bitpack_pkg::*;
(
    input  lane_desc_t desc,
    output lane_code_t lane
);

    logic [LANE_MAXBITS-1:0] acc_s;
    logic [6:0]              len_s;

    // Grow the codeword right-aligned field by field, then left-align it
    always_comb begin
        acc_s = ~({LANE_MAXBITS{1'b1}} << desc.oc);
        acc_s = (acc_s << desc.pc) | {77'd0, desc.pv & ~(15'h7FFF << desc.pc)};
        acc_s = acc_s << desc.zc;
        acc_s = (acc_s << desc.bc) | {76'd0, {7'd0, desc.bv} & ~(16'hFFFF << desc.bc)};
        len_s = 7'(desc.oc) + 7'(desc.pc) + 7'(desc.zc) + 7'(desc.bc);
        if (desc.vl) begin
            lane.code = acc_s << (7'd92 - len_s);
            lane.len  = len_s;
        end else begin
            lane.code = '0;
            lane.len  = 7'd0;
        end
    end

endmodule

// File: rtl/bitpack8.sv
// Three-stage packer: per-lane codewords, group concatenation, word emission with residual.
// Define BITPACK_BITCNT_EN to add the o_bitcnt per-frame payload bit counter.
module bitpack8
    import bitpack_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_et,
    input  logic              i_vl [1:NLANE],
    input  logic [4:0]        i_oc [1:NLANE],
    input  logic [14:0]       i_pv [1:NLANE],
    input  logic [3:0]        i_pc [1:NLANE],
    input  logic [4:0]        i_zc [1:NLANE],
    input  logic [8:0]        i_bv [1:NLANE],
    input  logic [3:0]        i_bc [1:NLANE],
    output logic              o_et,
    output logic [3:0]        o_wn,
    output logic [WW-1:0]     o_wd [0:NWORD-1]
`ifdef BITPACK_BITCNT_EN
    ,
    output logic [31:0]       o_bitcnt
`endif
);

    localparam int CATW = NWORD * WW;

    lane_desc_t               desc_s [NLANE];
    lane_code_t               a_lane_d [NLANE];
    lane_code_t               a_lane_q [NLANE];
    logic                     a_et_d, a_et_q;

    logic [9:0]               off_s [0:NLANE];
    logic [GRP_MAXBITS-1:0]   b_grp_d, b_grp_q;
    logic [9:0]               b_len_d, b_len_q;
    logic                     b_et_d, b_et_q;

    logic [CATW-1:0]          cat_s;
    logic [9:0]               tot_s;
    logic [3:0]               nfull_s;
    logic [WW-1:0]            tail_s;
    logic [WW-1:0]            wd_d [0:NWORD-1];
    logic [WW-1:0]            wd_q [0:NWORD-1];
    logic [3:0]               wn_d, wn_q;
    logic                     et_d, et_q;
    logic [WW-1:0]            res_d, res_q;
    logic [5:0]               res_len_d, res_len_q;

    // Map the lane-indexed ports onto descriptor structs
    always_comb begin
        for (int i = 0; i < NLANE; i++) begin
            desc_s[i].vl = i_vl[i+1];
            desc_s[i].oc = i_oc[i+1];
            desc_s[i].pv = i_pv[i+1];
            desc_s[i].pc = i_pc[i+1];
            desc_s[i].zc = i_zc[i+1];
            desc_s[i].bv = i_bv[i+1];
            desc_s[i].bc = i_bc[i+1];
        end
        a_et_d = i_et;
    end

    for (genvar g = 0; g < NLANE; g++) begin : g_lane
        bitpack_lane u_lane (
            .desc (desc_s[g]),
            .lane (a_lane_d[g])
        );
    end

    // Stage A register: per-lane codewords and frame-end flag
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NLANE; i++) begin
                a_lane_q[i] <= '0;
            end
            a_et_q <= 1'b0;
        end else begin
            for (int i = 0; i < NLANE; i++) begin
                a_lane_q[i] <= a_lane_d[i];
            end
            a_et_q <= a_et_d;
        end
    end

    // Prefix-sum lane offsets and OR each shifted lane into the group vector
    always_comb begin
        off_s[0] = 10'd0;
        b_grp_d  = '0;
        for (int i = 0; i < NLANE; i++) begin
            off_s[i+1] = off_s[i] + 10'(a_lane_q[i].len);
            b_grp_d    = b_grp_d |
                         ({a_lane_q[i].code, {(GRP_MAXBITS-LANE_MAXBITS){1'b0}}} >> off_s[i]);
        end
        b_len_d = off_s[NLANE];
        b_et_d  = a_et_q;
    end

    // Stage B register: concatenated group
    always_ff @(posedge clk) begin
        if (rst) begin
            b_grp_q <= '0;
            b_len_q <= 10'd0;
            b_et_q  <= 1'b0;
        end else begin
            b_grp_q <= b_grp_d;
            b_len_q <= b_len_d;
            b_et_q  <= b_et_d;
        end
    end

    // Append the group behind the residual, slice whole words, flush on frame end
    always_comb begin
        cat_s   = {res_q, {(CATW-WW){1'b0}}} |
                  ({b_grp_q, {(CATW-GRP_MAXBITS){1'b0}}} >> res_len_q);
        tot_s   = 10'(res_len_q) + b_len_q;
        nfull_s = tot_s[9:6];
        tail_s  = '0;
        for (int k = 0; k < NWORD; k++) begin
            tail_s = tail_s | ((4'(k) == nfull_s) ? cat_s[CATW-1-WW*k -: WW] : {WW{1'b0}});
            if (4'(k) < nfull_s) begin
                wd_d[k] = cat_s[CATW-1-WW*k -: WW];
            end else if (b_et_q && (4'(k) == nfull_s) && (tot_s[5:0] != 6'd0)) begin
                wd_d[k] = cat_s[CATW-1-WW*k -: WW];
            end else begin
                wd_d[k] = '0;
            end
        end
        if (b_et_q) begin
            res_d     = '0;
            res_len_d = 6'd0;
            if (tot_s[5:0] != 6'd0) begin
                wn_d = nfull_s + 4'd1;
            end else begin
                wn_d = nfull_s;
            end
        end else begin
            res_d     = tail_s;
            res_len_d = tot_s[5:0];
            wn_d      = nfull_s;
        end
        et_d = b_et_q;
    end

    // Stage C register: output words and residual
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NWORD; k++) begin
                wd_q[k] <= '0;
            end
            wn_q      <= 4'd0;
            et_q      <= 1'b0;
            res_q     <= '0;
            res_len_q <= 6'd0;
        end else begin
            for (int k = 0; k < NWORD; k++) begin
                wd_q[k] <= wd_d[k];
            end
            wn_q      <= wn_d;
            et_q      <= et_d;
            res_q     <= res_d;
            res_len_q <= res_len_d;
        end
    end

    assign o_wd = wd_q;
    assign o_wn = wn_q;
    assign o_et = et_q;

`ifdef BITPACK_BITCNT_EN
    logic [31:0] cnt_d, cnt_q;
    logic [32:0] cnt_sum_s;

    // Per-frame payload count; restarts on the group after a frame end
    always_comb begin
        if (et_q) begin
            cnt_sum_s = {23'd0, b_len_q};
        end else begin
            cnt_sum_s = {1'b0, cnt_q} + {23'd0, b_len_q};
        end
        if (cnt_sum_s[32]) begin
            cnt_d = 32'hFFFF_FFFF;
        end else begin
            cnt_d = cnt_sum_s[31:0];
        end
    end

    // Frame bit counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_bitcnt = cnt_q;
`endif

endmodule

// File: tb/tb_bitpack8.sv
// Bench for bitpack8: bit-queue stream model checked every cycle, plus literal expectations.
module tb_bitpack8;
    import bitpack_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_et;
    logic        i_vl [1:8];
    logic [4:0]  i_oc [1:8];
    logic [14:0] i_pv [1:8];
    logic [3:0]  i_pc [1:8];
    logic [4:0]  i_zc [1:8];
    logic [8:0]  i_bv [1:8];
    logic [3:0]  i_bc [1:8];
    logic        o_et;
    logic [3:0]  o_wn;
    logic [63:0] o_wd [0:12];
`ifdef BITPACK_BITCNT_EN
    logic [31:0] o_bitcnt;
    longint      exp_cnt = 0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bitpack8 dut (
        .clk  (clk),  .rst  (rst),  .i_et (i_et),
        .i_vl (i_vl), .i_oc (i_oc), .i_pv (i_pv), .i_pc (i_pc),
        .i_zc (i_zc), .i_bv (i_bv), .i_bc (i_bc),
        .o_et (o_et), .o_wn (o_wn), .o_wd (o_wd)
`ifdef BITPACK_BITCNT_EN
        , .o_bitcnt (o_bitcnt)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic clear_inputs();
        i_et = 1'b0;
        for (int l = 1; l <= 8; l++) begin
            i_vl[l] = 1'b0; i_oc[l] = 5'd0; i_pv[l] = 15'd0; i_pc[l] = 4'd0;
            i_zc[l] = 5'd0; i_bv[l] = 9'd0; i_bc[l] = 4'd0;
        end
    endtask

    task automatic set_lane(input int l, input logic vl, input logic [4:0] oc, input logic [14:0] pv,
                            input logic [3:0] pc, input logic [4:0] zc, input logic [8:0] bv,
                            input logic [3:0] bc);
        i_vl[l] = vl; i_oc[l] = oc; i_pv[l] = pv; i_pc[l] = pc;
        i_zc[l] = zc; i_bv[l] = bv; i_bc[l] = bc;
    endtask

    task automatic set_byte_lanes();
        for (int l = 1; l <= 8; l++) set_lane(l, 1'b1, 5'd0, 15'd0, 4'd0, 5'd7, 9'h001, 4'd1);
    endtask

    task automatic set_max_lanes();
        for (int l = 1; l <= 8; l++) set_lane(l, 1'b1, 5'd31, 15'h7FFF, 4'd15, 5'd31, 9'h1FF, 4'd15);
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    // Stream model: groups as bit queues, a two-deep delay line, residual bit queue.
    bit          pa_q[$], pb_q[$], res_m[$];
    bit          pa_et = 1'b0, pb_et = 1'b0;
    logic [63:0] exp_wd [0:12];
    int          exp_wn = 0;
    bit          exp_et = 1'b0;
    bit          started = 1'b0;
    logic [14:0] bvx;
    logic [63:0] w;

    always @(posedge clk) begin
        started = 1'b1;
        if (rst) begin
            pa_q.delete(); pb_q.delete(); res_m.delete();
            pa_et = 1'b0; pb_et = 1'b0; exp_et = 1'b0; exp_wn = 0;
            for (int k = 0; k < 13; k++) exp_wd[k] = 64'd0;
`ifdef BITPACK_BITCNT_EN
            exp_cnt = 0;
`endif
        end else begin
`ifdef BITPACK_BITCNT_EN
            if (exp_et) exp_cnt = 0;
            exp_cnt = exp_cnt + pb_q.size();
            if (exp_cnt > 64'hFFFF_FFFF) exp_cnt = 64'hFFFF_FFFF;
`endif
            foreach (pb_q[i]) res_m.push_back(pb_q[i]);
            exp_wn = 0;
            for (int k = 0; k < 13; k++) exp_wd[k] = 64'd0;
            while (res_m.size() >= 64) begin
                w = 64'd0;
                for (int b = 0; b < 64; b++) w[63-b] = res_m.pop_front();
                exp_wd[exp_wn] = w;
                exp_wn++;
            end
            if (pb_et && res_m.size() > 0) begin
                w = 64'd0;
                for (int b = 0; res_m.size() > 0; b++) w[63-b] = res_m.pop_front();
                exp_wd[exp_wn] = w;
                exp_wn++;
            end
            exp_et = pb_et;
            pb_q = pa_q;
            pb_et = pa_et;
            pa_q.delete();
            for (int l = 1; l <= 8; l++) begin
                if (i_vl[l]) begin
                    bvx = {6'd0, i_bv[l]};
                    for (int b = 0; b < int'(i_oc[l]); b++) pa_q.push_back(1'b1);
                    for (int b = int'(i_pc[l]) - 1; b >= 0; b--) pa_q.push_back(i_pv[l][b]);
                    for (int b = 0; b < int'(i_zc[l]); b++) pa_q.push_back(1'b0);
                    for (int b = int'(i_bc[l]) - 1; b >= 0; b--) pa_q.push_back(bvx[b]);
                end
            end
            pa_et = i_et;
        end
    end

    // Per-cycle comparison against the model
    int bad;
    always @(negedge clk) begin
        if (started) begin
            chk("o_et", 64'(o_et), 64'(exp_et));
            chk("o_wn", 64'(o_wn), 64'(exp_wn));
            bad = -1;
            for (int k = 0; k < 13; k++) if (bad < 0 && o_wd[k] !== exp_wd[k]) bad = k;
            checks++;
            if (bad >= 0) begin
                errors++;
                $display("FAIL o_wd[%0d]: got %h expected %h", bad, o_wd[bad], exp_wd[bad]);
            end
`ifdef BITPACK_BITCNT_EN
            chk("o_bitcnt", 64'(o_bitcnt), 64'(exp_cnt));
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        repeat (3) nxt();
        chk("rst_wn", 64'(o_wn), 64'd0);
        chk("rst_et", 64'(o_et), 64'd0);
        chk("rst_wd0", o_wd[0], 64'd0);
        chk("rst_wd12", o_wd[12], 64'd0);
        rst = 1'b0;

        // single short lane ending the frame, then a byte-per-lane group back-to-back
        set_lane(1, 1'b1, 5'd0, 15'd0, 4'd0, 5'd2, 9'h005, 4'd3);
        i_et = 1'b1;
        nxt(); clear_inputs(); set_byte_lanes();
        nxt(); clear_inputs();
        nxt();
        chk("t1_et", 64'(o_et), 64'd1);
        chk("t1_wn", 64'(o_wn), 64'd1);
        chk("t1_wd0", o_wd[0], 64'h2800_0000_0000_0000);
        nxt();
        chk("t2_wn", 64'(o_wn), 64'd1);
        chk("t2_wd0", o_wd[0], 64'h0101_0101_0101_0101);
        chk("t2_r", 64'(res_m.size()), 64'd0);

        // two maximal groups, then a lone frame end
        set_max_lanes();
        nxt();
        nxt(); clear_inputs(); i_et = 1'b1;
        nxt(); clear_inputs();
        chk("t3a_wn", 64'(o_wn), 64'd11);
        chk("t3a_wd0", o_wd[0], 64'hFFFF_FFFF_FFFC_0000);
        chk("t3a_r", 64'(res_m.size()), 64'd32);
        nxt();
        chk("t3b_wn", 64'(o_wn), 64'd12);
        chk("t3b_r", 64'(res_m.size()), 64'd0);
        nxt();
        chk("t3c_et", 64'(o_et), 64'd1);
        chk("t3c_wn", 64'(o_wn), 64'd0);

        // lanes 2 and 5 valid, lane 3 loaded but invalid
        set_lane(2, 1'b1, 5'd3, 15'd0, 4'd0, 5'd0, 9'd0, 4'd0);
        set_lane(3, 1'b0, 5'd5, 15'h1234, 4'd8, 5'd3, 9'h1AB, 4'd7);
        set_lane(5, 1'b1, 5'd0, 15'd0, 4'd0, 5'd1, 9'h00A, 4'd4);
        i_et = 1'b1;
        nxt(); clear_inputs();
        nxt();
        nxt();
        chk("t4_wn", 64'(o_wn), 64'd1);
        chk("t4_wd0", o_wd[0], 64'hEA00_0000_0000_0000);

        // reset with 40 residual bits and two groups in flight
        set_lane(1, 1'b1, 5'd31, 15'd0, 4'd0, 5'd9, 9'd0, 4'd0);
        nxt(); clear_inputs(); set_byte_lanes();
        nxt(); clear_inputs(); set_byte_lanes();
        nxt(); clear_inputs(); rst = 1'b1;
        chk("t5_r", 64'(res_m.size()), 64'd40);
        nxt(); rst = 1'b0;
        chk("t5_wn0", 64'(o_wn), 64'd0);
        set_lane(1, 1'b1, 5'd0, 15'd0, 4'd0, 5'd2, 9'h005, 4'd3);
        i_et = 1'b1;
        nxt(); clear_inputs();
        chk("t5_wn1", 64'(o_wn), 64'd0);
        nxt();
        chk("t5_wn2", 64'(o_wn), 64'd0);
        nxt();
        chk("t5_wn3", 64'(o_wn), 64'd1);
        chk("t5_wd0", o_wd[0], 64'h2800_0000_0000_0000);

        // 150-bit frame over three groups, then an 8-bit frame
        set_lane(1, 1'b1, 5'd20, 15'd0, 4'd0, 5'd0, 9'd0, 4'd0);
        nxt();
        nxt(); clear_inputs();
        set_lane(1, 1'b1, 5'd31, 15'h7FFF, 4'd15, 5'd31, 9'h1FF, 4'd15);
        set_lane(2, 1'b1, 5'd18, 15'd0, 4'd0, 5'd0, 9'd0, 4'd0);
        i_et = 1'b1;
        nxt(); clear_inputs();
        set_lane(1, 1'b1, 5'd0, 15'd0, 4'd0, 5'd7, 9'h001, 4'd1);
        i_et = 1'b1;
        nxt(); clear_inputs();
        nxt();
        chk("t6_et", 64'(o_et), 64'd1);
        chk("t6_wn", 64'(o_wn), 64'd3);
        chk("t6_wd2", o_wd[2], 64'hFFFF_FC00_0000_0000);
`ifdef BITPACK_BITCNT_EN
        chk("t6_cnt", 64'(o_bitcnt), 64'd150);
`endif
        nxt();
        chk("t7_wn", 64'(o_wn), 64'd1);
        chk("t7_wd0", o_wd[0], 64'h0100_0000_0000_0000);
`ifdef BITPACK_BITCNT_EN
        chk("t7_cnt", 64'(o_bitcnt), 64'd8);
`endif
        repeat (3) nxt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bitpack8.md
Name: bitpack8

Overview:
- Downstream neighbour of the 8-lane inverse-sort stage in the JPEG-LS encoder.
- Each cycle it accepts up to 8 per-pixel codeword descriptors and concatenates them, lane 1 first.
- Fields per descriptor: run ones, run remainder, unary zeros, mapped-error bits.
- Output is a continuous MSB-first bitstream, emitted as whole 64-bit words; a frame-end flush pads the final partial word with zeros.

Parameters:
- NLANE, 8, lanes per cycle; fixed, not intended for override.
- WW, 64, output word width in bits.
- NWORD, 13, output word slots per cycle: ceil((63 + 8*92) / 64).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- i_et  in  1  end-of-frame flag; accompanies the frame's last lane group or arrives alone.
- i_vl[1:8]  in  1 each  lane valid.
- i_oc[1:8]  in  5 each  count of '1' bits (run segments), 0..31.
- i_pv[1:8]  in  15 each  run-remainder value.
- i_pc[1:8]  in  4 each  number of LSBs of i_pv to emit, 0..15.
- i_zc[1:8]  in  5 each  count of '0' bits (unary prefix), 0..31.
- i_bv[1:8]  in  9 each  suffix value.
- i_bc[1:8]  in  4 each  number of LSBs of i_bv to emit, 0..15; bit positions above 8 read as 0.
- o_et  out  1  frame end; flush words are present this cycle.
- o_wn  out  4  number of valid words in o_wd, 0..13.
- o_wd[0:12]  out  64 each  output words; o_wd[0] is earliest; bit 63 is the first stream bit.

Behaviour:
- Lane codeword, MSB-first: i_oc ones, then i_pc LSBs of i_pv (MSB first), then i_zc zeros, then i_bc LSBs of i_bv (MSB first).
- Lane length L = oc + pc + zc + bc, at most 92, 7 bits.
- A lane with i_vl=0 contributes 0 bits regardless of its other fields.
- Zero-length valid lanes are legal.
- Pipeline, 3 stages, all registered:
  - Stage A: per-lane codeword, left-aligned in 92 bits, plus L.
  - Stage B: prefix-sum offsets and concatenation into a group vector, up to 736 bits; group length G uses 10 bits.
  - Stage C: append the group to the residual register R (0..63 bits, left-aligned), then emit floor((R+G)/64) words and keep the remainder in R.
- Latency: input group at cycle t appears in o_wd/o_wn at cycle t+3; i_et appears on o_et at t+3.
- o_wd slots at index ≥ o_wn are 0.
- Flush: when stage C sees et, it first merges that cycle's group.
  - If the remaining R>0, one extra word is emitted: R bits left-aligned, zero-padded.
  - o_wn includes that word, maximum 13. R is then cleared to 0.
  - et with R=0 after the merge emits no pad word; o_et still asserts.
- The next frame's first input may arrive the cycle after i_et, back-to-back with no gap; frames never share a word.
- Reset, synchronous: o_et=0, o_wn=0, o_wd=all 0, R=0, all pipeline valid/et flags cleared.
  - Reset mid-frame discards every in-flight group and the residual; no flush is generated.
- No backpressure: the block accepts one group per cycle unconditionally.

Optional Feature:
- Macro: BITPACK_BITCNT_EN.
- Defined:
  - Adds output o_bitcnt (32 bits): the count of payload bits in the current frame, padding excluded.
  - Updated every cycle in stage C.
  - On the o_et cycle it holds the frame total, including that cycle's group.
  - Restarts from the next frame's first group.
  - Reset value 0; saturates at 2^32-1.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package bitpack_pkg:
  - Constants: NLANE=8, LANE_MAXBITS=92, GRP_MAXBITS=736, WW=64, NWORD=13.
  - typedef lane_desc_t, a packed struct {vl, oc, pv, pc, zc, bv, bc}.
  - typedef lane_code_t {code[91:0], len[6:0]}.
- Sub-module bitpack_lane: purely combinational construction of one lane's codeword and length; instantiated 8× in stage A.

Test Plan:
- After reset, lane1 only, oc=0, pc=0, zc=2, bv=9'h005, bc=3 (bits 00101), then i_et in the same cycle -> at t+3: o_et=1, o_wn=1, o_wd[0]=64'h2800_0000_0000_0000.
- 8 valid lanes, each zc=7, bc=1, bv=1 (code 0000_0001, 64 bits total) -> o_wn=1, o_wd[0]=64'h0101_0101_0101_0101, R=0.
- Max group: all lanes oc=31, pc=15, pv=15'h7FFF, zc=31, bc=15, bv=9'h1FF, no et, 2 consecutive cycles -> cycle 1: o_wn=11, R=32; cycle 2: o_wn=12, R=0. Words match a bit-level reference model.
- Valid lanes 2 and 5 only, with lane 3 carrying nonzero fields but i_vl=0 -> lane 3 absent from the stream; lane 2 bits precede lane 5 bits.
- rst asserted for 1 cycle while 2 groups are in flight with R=40 -> o_wn=0 on the following 3 cycles; a new frame starts with R=0 and no leftover bits.
- With BITPACK_BITCNT_EN: a frame of 3 groups totalling 150 bits -> o_bitcnt=150 on the o_et cycle, o_wn=3 on the flush cycle (128+22 bits, one pad word), then the counter restarts at the next frame.
